ysyx_22050058_lsu: RTL

- Load/store unit directly upstream of the data memory block.
- Accepts one memory op at a time from EX and drives the memory request interface: aligned address, byte write mask, lane-shifted write data.
- Waits for the memory's read/write valid, then extracts and sign/zero-extends load data.
- Hands the result to WB over a valid/ready handshake; flags misaligned accesses without touching memory.

---
 rtl/ysyx_22050058_lsu_pkg.sv | 29 ++
 rtl/ysyx_22050058_lsu_if.sv | 69 ++++++
 rtl/ysyx_22050058_lsu_align.sv | 63 ++++++
 rtl/ysyx_22050058_lsu.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/ysyx_22050058_lsu_pkg.sv
// Shared LSU types: funct3 codes, FSM states,
// byte-lane width, zero word and memory valid levels.
package ysyx_22050058_lsu_pkg;

  localparam int StoreSelBusNum = 8;
  localparam logic [63:0] ZeroWord = 64'h0;
  localparam logic RdValid = 1'b1;
  localparam logic WrValid = 1'b1;

  typedef enum logic [2:0] {
    F3_LB  = 3'b000,
    F3_LH  = 3'b001,
    F3_LW  = 3'b010,
    F3_LD  = 3'b011,
    F3_LBU = 3'b100,
    F3_LHU = 3'b101,
    F3_LWU = 3'b110,
    F3_BAD = 3'b111
  } funct3_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT_R,
    S_WAIT_W,
    S_DONE
  } state_e;

endpackage

// File: rtl/ysyx_22050058_lsu_if.sv
// LSU buses: ex (op in, ready out), mem (request/response),
// wb (result out, ready in). master = driver of the op/request/result.
interface ysyx_22050058_lsu_ex_if #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
);
  logic              valid_i;
  logic              ready_o;
  logic              load_i;
  logic              store_i;
  logic [2:0]        funct3_i;
  logic [ADDR_W-1:0] addr_i;
  logic [DATA_W-1:0] wdata_i;
  logic [4:0]        rd_i;

  modport master (
    output valid_i, load_i, store_i, funct3_i,
    output addr_i, wdata_i, rd_i,
    input  ready_o
  );
  modport slave (
    input  valid_i, load_i, store_i, funct3_i,
    input  addr_i, wdata_i, rd_i,
    output ready_o
  );
endinterface

interface ysyx_22050058_lsu_mem_if #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
);
  logic              ce_o;
  logic              memre_o;
  logic [7:0]        memwe_o;
  logic [ADDR_W-1:0] memaddr_o;
  logic [DATA_W-1:0] memwdata_o;
  logic [DATA_W-1:0] memrdata_i;
  logic              memrdatavaild_i;
  logic              memwdatavaild_i;

  modport master (
    output ce_o, memre_o, memwe_o, memaddr_o, memwdata_o,
    input  memrdata_i, memrdatavaild_i, memwdatavaild_i
  );
  modport slave (
    input  ce_o, memre_o, memwe_o, memaddr_o, memwdata_o,
    output memrdata_i, memrdatavaild_i, memwdatavaild_i
  );
endinterface

interface ysyx_22050058_lsu_wb_if #(
  parameter int DATA_W = 64
);
  logic              valid_o;
  logic              ready_i;
  logic [DATA_W-1:0] rdata_o;
  logic [4:0]        rd_o;
  logic              misalign_o;
  logic              fault_o;

  modport master (
    output valid_o, rdata_o, rd_o, misalign_o, fault_o,
    input  ready_i
  );
  modport slave (
    input  valid_o, rdata_o, rd_o, misalign_o, fault_o,
    output ready_i
  );
endinterface

// File: rtl/ysyx_22050058_lsu_align.sv
// Byte-lane helper: store mask/shift, load shift/extend, misalign check.
// Ports: off/funct3/wdata/rline -> mask/wlane/rext; chk_* -> misalign.
module ysyx_22050058_lsu_align
  import ysyx_22050058_lsu_pkg::*;
#(
  parameter int DATA_W = 64
) (
  input  logic [2:0]                off,
  input  logic [2:0]                funct3,
  input  logic [DATA_W-1:0]         wdata,
  input  logic [DATA_W-1:0]         rline,
  input  logic [2:0]                chk_off,
  input  logic [2:0]                chk_funct3,
  output logic [StoreSelBusNum-1:0] mask,
  output logic [DATA_W-1:0]         wlane,
  output logic [DATA_W-1:0]         rext,
  output logic                      misalign
);

  logic [1:0]        sz;
  logic [1:0]        csz;
  logic [DATA_W-1:0] rsh;

  assign sz    = funct3[1:0];
  assign csz   = chk_funct3[1:0];
  assign wlane = wdata << {off, 3'b000};
  assign rsh   = rline >> {off, 3'b000};

  always_comb begin
    mask = '0;
    unique case (1'b1)
      sz == 2'b00: mask = 8'h01 << off;
      sz == 2'b01: mask = 8'h03 << off;
      sz == 2'b10: mask = 8'h0F << off;
      sz == 2'b11: mask = 8'hFF;
    endcase
  end

  always_comb begin
    misalign = 1'b0;
    unique case (1'b1)
      csz == 2'b00: misalign = 1'b0;
      csz == 2'b01: misalign = chk_off[0];
      csz == 2'b10: misalign = |chk_off[1:0];
      csz == 2'b11: misalign = |chk_off;
    endcase
  end

  always_comb begin
    rext = rsh;
    case (funct3)
      F3_LB:  rext = {{(DATA_W-8){rsh[7]}}, rsh[7:0]};
      F3_LH:  rext = {{(DATA_W-16){rsh[15]}}, rsh[15:0]};
      F3_LW:  rext = {{(DATA_W-32){rsh[31]}}, rsh[31:0]};
      F3_LBU: rext = {{(DATA_W-8){1'b0}}, rsh[7:0]};
      F3_LHU: rext = {{(DATA_W-16){1'b0}}, rsh[15:0]};
      F3_LWU: rext = {{(DATA_W-32){1'b0}}, rsh[31:0]};
      F3_LD:  rext = rsh;
      default: rext = rsh;
    endcase
  end

endmodule

// File: rtl/ysyx_22050058_lsu.sv
// Load/store unit: one op in flight, EX -> memory -> WB.
// Ports: clk, rst (async low), ex/mem/wb buses. Option: YSYX_22050058_LSU_TIMEOUT_EN.
module ysyx_22050058_lsu
  import ysyx_22050058_lsu_pkg::*;
#(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
`ifdef YSYX_22050058_LSU_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYCLES = 255
`endif
) (
  input  logic                   clk,
  input  logic                   rst,
  ysyx_22050058_lsu_ex_if.slave  ex,
  ysyx_22050058_lsu_mem_if.master mem,
  ysyx_22050058_lsu_wb_if.master wb
);

  state_e                    state;
  state_e                    state_nxt;
  logic [ADDR_W-1:0]         addr_q;
  logic [2:0]                f3_q;
  logic [DATA_W-1:0]         wdata_q;
  logic [DATA_W-1:0]         rdata_q;
  logic [4:0]                rd_q;
  logic                      load_q;
  logic                      mis_q;
  logic                      flt_q;
  logic                      ce_q;
  logic [StoreSelBusNum-1:0] mask;
  logic [DATA_W-1:0]         wlane;
  logic [DATA_W-1:0]         rext;
  logic                      mis_in;
  logic                      accept;
  logic                      both;
  logic                      none;
  logic                      bad;
  logic                      go_req;
  logic                      rvalid;
  logic                      wvalid;
  logic                      tmo;

  ysyx_22050058_lsu_align #(.DATA_W(DATA_W)) u_align (
    .off        (addr_q[2:0]),
    .funct3     (f3_q),
    .wdata      (wdata_q),
    .rline      (mem.memrdata_i),
    .chk_off    (ex.addr_i[2:0]),
    .chk_funct3 (ex.funct3_i),
    .mask       (mask),
    .wlane      (wlane),
    .rext       (rext),
    .misalign   (mis_in)
  );

  assign ex.ready_o = (state == S_IDLE) & ce_q;
  assign accept     = ex.valid_i & ex.ready_o;
  assign both       = ex.load_i & ex.store_i;
  assign none       = ~ex.load_i & ~ex.store_i;
  assign bad        = ex.funct3_i == F3_BAD;
  assign go_req     = ~both & ~none & ~bad & ~mis_in;
  assign rvalid     = mem.memrdatavaild_i == RdValid;
  assign wvalid     = mem.memwdatavaild_i == WrValid;

`ifdef YSYX_22050058_LSU_TIMEOUT_EN
  localparam int CntW =
    ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  logic [CntW-1:0] cnt;
  logic            waiting;

  assign waiting = (state == S_WAIT_R) | (state == S_WAIT_W);
  assign tmo     = waiting & (cnt == CntW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (state == S_REQ) begin
      cnt <= '0;
    end else if (waiting) begin
      cnt <= cnt + 1'b1;
    end
  end
`else
  assign tmo = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:   if (accept) state_nxt = go_req ? S_REQ : S_DONE;
      S_REQ:    state_nxt = load_q ? S_WAIT_R : S_WAIT_W;
      S_WAIT_R: if (rvalid | tmo) state_nxt = S_DONE;
      S_WAIT_W: if (wvalid | tmo) state_nxt = S_DONE;
      S_DONE:   if (wb.ready_i) state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ce_q    <= 1'b0;
      addr_q  <= '0;
      f3_q    <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      rd_q    <= '0;
      load_q  <= 1'b0;
      mis_q   <= 1'b0;
      flt_q   <= 1'b0;
    end else begin
      ce_q <= 1'b1;
      unique case (state)
        S_IDLE: if (accept) begin
          addr_q  <= ex.addr_i;
          f3_q    <= ex.funct3_i;
          wdata_q <= ex.wdata_i;
          rd_q    <= ex.rd_i;
          load_q  <= ex.load_i & ~ex.store_i;
          mis_q   <= ~both & ~none & ~bad & mis_in;
          flt_q   <= both | (~none & bad);
          rdata_q <= ZeroWord;
        end
        S_WAIT_R: begin
          if (rvalid)   rdata_q <= rext;
          else if (tmo) flt_q   <= 1'b1;
        end
        S_WAIT_W: if (!wvalid && tmo) flt_q <= 1'b1;
        S_DONE: if (wb.ready_i) begin
          rdata_q <= ZeroWord;
          mis_q   <= 1'b0;
          flt_q   <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  // request pulses are pure state decodes, so they exist only in REQ
  assign mem.ce_o       = ce_q;
  assign mem.memre_o    = (state == S_REQ) & load_q;
  assign mem.memwe_o    = ((state == S_REQ) & ~load_q) ? mask : '0;
  assign mem.memaddr_o  = {addr_q[ADDR_W-1:3], 3'b000};
  assign mem.memwdata_o = wlane;

  assign wb.valid_o    = state == S_DONE;
  assign wb.rdata_o    = rdata_q;
  assign wb.rd_o       = rd_q;
  assign wb.misalign_o = mis_q;
  assign wb.fault_o    = flt_q;

endmodule
